// File: rtl/bus_pkg.sv
// Shared encodings for the memory bus responder: burst codes, FSM states
// and the beat-count helper used by the control logic.
package bus_pkg;

  typedef enum logic [1:0] {
    BURST_SINGLE = 2'b00,
    BURST_INCR   = 2'b01,
    BURST_WRAP   = 2'b10,
    BURST_RSVD   = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int BURST_LEN_DEFAULT = 8;
  localparam int BEAT_W            = 4;

  // A burst length of 16 truncates to 0, so the last beat index still lands on 15.
  function automatic logic [BEAT_W-1:0] beats_for(input burst_e burst, input int len);
    logic [BEAT_W-1:0] n;
    n = (burst == BURST_SINGLE) ? 4'd1 : len[BEAT_W-1:0];
    return n;
  endfunction

endpackage

// File: rtl/bus_addr_gen.sv
// Beat address generator: single bursts hold the base, INCR steps by one
// word per beat, WRAP rotates ADDR[4:2] within the aligned 32-byte block.
module bus_addr_gen
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [BEAT_W-1:0]     beat,
  input  burst_e                burst,
  output logic [ADDR_WIDTH-1:0] address
);

  logic [2:0] wrap_idx;

  always_comb begin
    wrap_idx = base[4:2] + beat[2:0];
    address  = base;
    case (burst)
      BURST_INCR: address = base + {{(ADDR_WIDTH-BEAT_W-2){1'b0}}, beat, 2'b00};
      BURST_WRAP: address = {base[ADDR_WIDTH-1:5], wrap_idx, base[1:0]};
      default:    address = base;
    endcase
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Bus slave that answers single/INCR/WRAP transfers from a synchronous SRAM
// with one cycle of read latency, optional wait states and abort on REQ drop.
module mem_bus_responder
  import bus_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter int         BURST_LEN   = BURST_LEN_DEFAULT,
  parameter int         WAIT_STATES = 0,
  parameter logic [1:0] SEL_VALUE   = 2'b00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [1:0]            BURST,
  input  logic                  REQ,
  input  logic                  WRB,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            BSTROBE,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  ACK,
  output logic                  STALL,
  output logic                  ERR,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [BEAT_W-1:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  state_e                state, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [BEAT_W-1:0]     wait_q, wait_d;
  logic                  drain_q, drain_d;
  logic                  err_q, err_d;
  logic                  rd_ack_p1;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] base_q;
  burst_e                burst_q;
  logic                  wrb_q;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [BEAT_W-1:0]     n_beats;
  logic                  sel_hit;
  logic                  last_beat;
  logic                  issue;

  assign sel_hit   = REQ && (ADDR[15:14] == SEL_VALUE);
  assign n_beats   = beats_for(burst_q, BURST_LEN);
  assign last_beat = (beat_q == n_beats - 4'd1);
  // Beats are only issued while the master still holds REQ, so an abort
  // suppresses the SRAM access and the trailing read ACK at once.
  assign issue     = (state == XFER) && !drain_q && REQ;

  always_comb begin
    state_d = state;
    beat_d  = beat_q;
    wait_d  = wait_q;
    drain_d = drain_q;
    err_d   = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (sel_hit) begin
          if (BURST == BURST_RSVD) begin
            err_d = 1'b1;
          end else begin
            capture = 1'b1;
            beat_d  = '0;
            wait_d  = '0;
            drain_d = 1'b0;
            state_d = (WAIT_STATES > 0) ? WAIT : XFER;
          end
        end
      end
      WAIT: begin
        if (!REQ)                    state_d = IDLE;
        else if (wait_q == WAIT_LAST) state_d = XFER;
        else                         wait_d  = wait_q + 4'd1;
      end
      XFER: begin
        if (!REQ) begin
          state_d = IDLE;
        end else if (drain_q) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + 4'd1;
          if (last_beat) begin
            // Reads spend one extra XFER cycle so the last registered ACK
            // is not shown in DONE.
            if (wrb_q) state_d = DONE;
            else       drain_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_q    <= '0;
      wait_q    <= '0;
      drain_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_ack_p1 <= 1'b0;
    end else begin
      state     <= state_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      rd_ack_p1 <= issue && !wrb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      base_q  <= ADDR;
      burst_q <= burst_e'(BURST);
      wrb_q   <= WRB;
    end
  end

  bus_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .base   (base_q),
    .beat   (beat_q),
    .burst  (burst_q),
    .address(beat_addr)
  );

  // Stage p1: read data returns from the SRAM alongside the registered ACK.
  always_comb begin
    STALL     = (state == WAIT);
    ERR       = err_q;
    mem_en    = issue;
    mem_we    = (issue && wrb_q) ? BSTROBE : 4'b0000;
    mem_addr  = issue ? beat_addr : '0;
    mem_wdata = (issue && wrb_q) ? WDATA : '0;
    ACK       = (issue && wrb_q) || rd_ack_p1;
    RDATA     = rd_ack_p1 ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance without wait states and
// one with three, each backed by a small behavioural SRAM.
module tb_mem_bus_responder;

  logic        clk;
  logic        rst;
  logic        req0, req1, wrb;
  logic [31:0] addr, wdata;
  logic [1:0]  burst;
  logic [3:0]  bstrobe;

  logic [31:0] rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        ack0, stall0, err0, mem_en0;
  logic [3:0]  mem_we0;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        ack1, stall1, err1, mem_en1;
  logic [3:0]  mem_we1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr [16];
  logic [31:0] exp_data [16];
  logic [31:0] addr_log [16];
  logic [31:0] rdata_log [16];
  logic [31:0] wrap_tab [8] = '{32'h18, 32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};

  mem_bus_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ADDR(addr), .BURST(burst), .REQ(req0), .WRB(wrb),
    .WDATA(wdata), .BSTROBE(bstrobe), .RDATA(rdata0), .ACK(ack0), .STALL(stall0),
    .ERR(err0), .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  mem_bus_responder #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst), .ADDR(addr), .BURST(burst), .REQ(req1), .WRB(wrb),
    .WDATA(wdata), .BSTROBE(bstrobe), .RDATA(rdata1), .ACK(ack1), .STALL(stall1),
    .ERR(err1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init0(input logic [5:0] i);
    return (i == 6'd4) ? 32'hDEADBEEF : (32'h1000_0000 | {26'd0, i});
  endfunction

  function automatic logic [31:0] init1(input logic [5:0] i);
    return 32'h2000_0000 | {26'd0, i};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAMs: untouched words return their initial pattern.
  logic [31:0] mem0 [64];
  bit          wr0 [64];
  logic [31:0] cur0;
  assign cur0 = wr0[mem_addr0[7:2]] ? mem0[mem_addr0[7:2]] : init0(mem_addr0[7:2]);

  always @(posedge clk) begin
    if (mem_en0) begin
      if (mem_we0 != 4'b0000) begin
        mem0[mem_addr0[7:2]] <= merge(cur0, mem_wdata0, mem_we0);
        wr0[mem_addr0[7:2]]  <= 1'b1;
      end
      mem_rdata0 <= cur0;
    end
  end

  always @(posedge clk) if (mem_en1) mem_rdata1 <= init1(mem_addr1[7:2]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read transfer on the zero-wait instance; REQ drops in the DONE cycle.
  task automatic read_xfer(input string tag, input logic [31:0] a, input logic [1:0] b,
                           input int n);
    int  nk, na, first, last, extra;
    bit  done;
    nk = 0; na = 0; first = -1; last = -1; extra = 0; done = 0;
    addr = a; burst = b; wrb = 1'b0; req0 = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_en0) begin
        if (na < 16) addr_log[na] = mem_addr0;
        na++;
      end
      if (ack0) begin
        if (nk < 16) rdata_log[nk] = rdata0;
        if (first < 0) first = c;
        last = c;
        nk++;
      end
      @(posedge clk); #1;
      if (nk == n) done = 1;
    end
    req0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack0 || mem_en0) extra++;
      @(posedge clk); #1;
    end
    chk({tag, " ack count"}, nk, n);
    chk({tag, " sram reads"}, na, n);
    chk({tag, " first ack cycle"}, first, 2);
    chk({tag, " ack span"}, last - first, n - 1);
    chk({tag, " trailing activity"}, extra, 0);
    for (int i = 0; i < n && i < nk && i < na; i++) begin
      chk($sformatf("%s mem_addr%0d", tag, i), addr_log[i], exp_addr[i]);
      chk($sformatf("%s rdata%0d", tag, i), rdata_log[i], exp_data[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int nst, fst, nk, fk, late, n_en, n_ack;
    bit dropped, en5, ack6;
    logic [31:0] rd6;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wrb = 1'b0;
    addr = '0; wdata = '0; burst = 2'b00; bstrobe = 4'b0000;

    @(negedge clk);
    chk("reset ctrl", 32'({ack0, stall0, err0, mem_en0, mem_we0}), 32'd0);
    chk("reset mem_addr", mem_addr0, 32'd0);
    chk("reset rdata", rdata0, 32'd0);
    chk("reset mem_wdata", mem_wdata0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    exp_addr[0] = 32'h10; exp_data[0] = 32'hDEADBEEF;
    read_xfer("single rd", 32'h10, 2'b00, 1);

    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = 32'(4 * i);
      exp_data[i] = init0(6'(i));
    end
    read_xfer("incr rd", 32'h0, 2'b01, 8);

    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = wrap_tab[i];
      exp_data[i] = init0(wrap_tab[i][7:2]);
    end
    read_xfer("wrap rd", 32'h18, 2'b10, 8);

    addr = 32'h20; burst = 2'b00; wrb = 1'b1; wdata = 32'h12345678; bstrobe = 4'b0011;
    req0 = 1'b1;
    @(negedge clk);
    chk("wr idle mem_en", 32'(mem_en0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr mem_we", 32'(mem_we0), 32'h3);
    chk("wr mem_en", 32'(mem_en0), 32'd1);
    chk("wr ack", 32'(ack0), 32'd1);
    chk("wr mem_addr", mem_addr0, 32'h20);
    chk("wr mem_wdata", mem_wdata0, 32'h12345678);
    @(posedge clk); #1;
    req0 = 1'b0; wrb = 1'b0; bstrobe = 4'b0000;
    @(negedge clk);
    chk("wr done quiet", 32'({ack0, mem_en0, mem_we0}), 32'd0);
    @(posedge clk); #1;
    exp_addr[0] = 32'h20; exp_data[0] = 32'h1000_5678;
    read_xfer("wr readback", 32'h20, 2'b00, 1);

    addr = 32'h40; burst = 2'b11; req0 = 1'b1;
    @(negedge clk);
    chk("err before", 32'(err0), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("err pulse", 32'(err0), 32'd1);
    chk("err no access", 32'({ack0, mem_en0, stall0}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err cleared", 32'(err0), 32'd0);
    @(posedge clk); #1;

    addr = 32'h0000_4010; burst = 2'b00; req0 = 1'b1; late = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack0 || mem_en0 || stall0 || err0) late++;
      @(posedge clk); #1;
    end
    req0 = 1'b0;
    chk("unselected ignored", late, 0);

    addr = 32'h10; burst = 2'b00; wrb = 1'b0;
    n_en = 0; n_ack = 0; en5 = 0; ack6 = 0; rd6 = '0;
    for (int c = 0; c < 10; c++) begin
      req0 = (c < 7);
      @(negedge clk);
      if (mem_en0) n_en++;
      if (ack0) n_ack++;
      if (c == 5) en5 = mem_en0;
      if (c == 6) begin ack6 = ack0; rd6 = rdata0; end
      @(posedge clk); #1;
    end
    chk("reaccept reads", n_en, 2);
    chk("reaccept acks", n_ack, 2);
    chk("reaccept en cycle", 32'(en5), 32'd1);
    chk("reaccept ack cycle", 32'(ack6), 32'd1);
    chk("reaccept rdata", rd6, 32'hDEADBEEF);

    addr = 32'h0; burst = 2'b01; wrb = 1'b0; req1 = 1'b1;
    nst = 0; fst = -1; nk = 0; fk = -1; late = 0; dropped = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall1) begin
        nst++;
        if (fst < 0) fst = c;
      end
      if (dropped && (ack1 || mem_en1 || stall1)) late++;
      if (ack1 && !dropped) begin
        if (fk < 0) fk = c;
        chk($sformatf("ws rdata%0d", nk), rdata1, 32'h2000_0000 | 32'(nk));
        nk++;
        if (nk == 4) begin
          req1 = 1'b0;
          dropped = 1;
        end
      end
      @(posedge clk); #1;
    end
    chk("ws stall cycles", nst, 3);
    chk("ws first stall", fst, 1);
    chk("ws first ack", fk, 5);
    chk("ws ack count", nk, 4);
    chk("ws after abort", late, 0);

    req1 = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("mid-burst ack", 32'(ack1), 32'd1);
    chk("mid-burst mem_en", 32'(mem_en1), 32'd1);
    #2 rst = 1'b1;
    req1 = 1'b0;
    #1;
    chk("async rst ctrl", 32'({ack1, stall1, err1, mem_en1, mem_we1}), 32'd0);
    chk("async rst mem_addr", mem_addr1, 32'd0);
    chk("async rst rdata", rdata1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post rst idle", 32'({ack1, stall1, mem_en1, ack0, mem_en0}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
